// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the parametrised AHB-Lite to APB3 bridge.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Ceiling log2, used to size the slot index field and the timeout counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ahb2apb_timeout_ctr.sv
// APB hang watchdog: counts PREADY-low ACCESS cycles and flags when the
// limit is reached. Only instantiated when APB_TIMEOUT_EN is defined.
module ahb2apb_timeout_ctr #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [WIDTH-1:0] count_q;

  // Wait-cycle counter, zeroed just before each ACCESS phase begins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire_o = (count_q == LIMIT[WIDTH-1:0]);

endmodule

// File: rtl/ahb2apb_bridge_nslot.sv
// AHB-Lite slave to APB3 master bridge with NSLOTS decoded PSEL lines,
// PREADY wait states, two-cycle ERROR responses for PSLVERR and decode
// misses. Define APB_TIMEOUT_EN to add a watchdog that aborts an ACCESS
// phase after TIMEOUT_CYCLES PREADY-low cycles.
module ahb2apb_bridge_nslot
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NSLOTS         = 16,
  parameter int SLOT_LSB       = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [NSLOTS-1:0]     PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int SLOT_BITS = clog2(NSLOTS);
  localparam int SLOT_W    = (SLOT_BITS < 1) ? 1 : SLOT_BITS;
  localparam logic [SLOT_W:0] NSLOTS_V = NSLOTS[SLOT_W:0];

  state_e                  state_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [NSLOTS-1:0]       psel_q;
  logic                    penable_q;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;

  logic [SLOT_W-1:0]       slot_idx;
  logic                    slot_hit;
  logic                    xfer_valid;
  logic                    timeout_hit;

  // A single-slot bridge has no index field, so every address maps to slot 0.
  if (SLOT_BITS == 0) begin : g_one_slot
    assign slot_idx = '0;
  end else begin : g_slot_field
    assign slot_idx = HADDR[SLOT_LSB +: SLOT_W];
  end

  assign slot_hit   = ({1'b0, slot_idx} < NSLOTS_V);
  assign xfer_valid = HSEL && HREADYIN &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef APB_TIMEOUT_EN
  localparam int TO_RAW = clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

  ahb2apb_timeout_ctr #(
    .WIDTH (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (HCLK),
    .rst_ni   (HRESETN),
    .clear_i  (state_q == SETUP),
    .enable_i ((state_q == ACCESS) && !PREADY),
    .expire_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Bridge FSM; every bus output is registered alongside the state it belongs to.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_valid) begin
            hreadyout_q <= 1'b0;
            if (slot_hit) begin
              paddr_q  <= HADDR;
              pwrite_q <= HWRITE;
              slot_q   <= slot_idx;
              state_q  <= LATCH;
            end else begin
              hresp_q <= HRESP_ERROR;
              state_q <= ERR1;
            end
          end
        end
        LATCH: begin
          if (pwrite_q) begin
            pwdata_q <= HWDATA;
          end
          psel_q  <= NSLOTS'(1) << slot_q;
          state_q <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (timeout_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            hresp_q   <= HRESP_ERROR;
            state_q   <= ERR1;
          end else if (PREADY) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (PSLVERR) begin
              hresp_q <= HRESP_ERROR;
              state_q <= ERR1;
            end else begin
              hreadyout_q <= 1'b1;
              state_q     <= IDLE;
              if (!pwrite_q) begin
                hrdata_q <= PRDATA;
              end
            end
          end
        end
        ERR1: begin
          hreadyout_q <= 1'b1;
          state_q     <= ERR2;
        end
        ERR2: begin
          hresp_q <= HRESP_OKAY;
          state_q <= IDLE;
        end
        default: begin
          psel_q      <= '0;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule
